// File: rtl/regfile_op_sequencer.sv
// Command sequencer for the 8x16 2R/1W register file: read both operands,
// run the ALU, write the result back and pulse a response.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high once out of reset
// READ  | read addresses driven, operands captured at end of cycle
// EXEC  | ALU result/carry/zero registered
// WRITE | single-cycle write-back and response pulse
`timescale 1ns/1ps
module regfile_op_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_src_a,
   input  logic [ADDR_W-1:0] cmd_src_b,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [ADDR_W-1:0] rf_rd_addr_a,
   output logic [ADDR_W-1:0] rf_rd_addr_b,
   input  logic [DATA_W-1:0] rf_d_out_a,
   input  logic [DATA_W-1:0] rf_d_out_b,
   output logic              rf_wr,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_d_in,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              rsp_zero
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_LDI = 3'd6;
   localparam logic [2:0] OP_NOT = 3'd7;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t            state, state_nxt;
   logic              armed;
   logic              accept;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] dst_q, src_a_q, src_b_q;
   logic [DATA_W-1:0] op_a, op_b, result;
   logic              carry, zero;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // armed keeps cmd_ready low until the first edge after reset release
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rf_wr     = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = armed;
            accept    = armed & cmd_valid;
            if (accept) state_nxt = (cmd_op == OP_LDI) ? WRITE : READ;
         end
         READ:  state_nxt = EXEC;
         EXEC:  state_nxt = WRITE;
         WRITE: begin
            rf_wr     = 1'b1;
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum       = '0;
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op_q)
         OP_ADD: begin
            sum       = {1'b0, op_a} + {1'b0, op_b};
            alu_res   = sum[DATA_W-1:0];
            alu_carry = sum[DATA_W];
         end
         OP_SUB: begin
            alu_res   = op_a - op_b;
            alu_carry = (op_a < op_b);
         end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_MOV:  alu_res = op_a;
         OP_NOT:  alu_res = ~op_a;
         default: alu_res = op_a;
      endcase
   end

   // result/carry/zero only change on the edge entering WRITE, so the
   // response fields hold between write-backs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed   <= 1'b0;
         op_q    <= '0;
         dst_q   <= '0;
         src_a_q <= '0;
         src_b_q <= '0;
         op_a    <= '0;
         op_b    <= '0;
         result  <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (accept) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            if (cmd_op == OP_LDI) begin
               result <= cmd_imm;
               carry  <= 1'b0;
               zero   <= (cmd_imm == '0);
            end
         end
         if (state == READ) begin
            op_a <= rf_d_out_a;
            op_b <= rf_d_out_b;
         end
         if (state == EXEC) begin
            result <= alu_res;
            carry  <= alu_carry;
            zero   <= (alu_res == '0);
         end
      end
   end

   assign rf_rd_addr_a = src_a_q;
   assign rf_rd_addr_b = src_b_q;
   assign rf_wr_addr   = dst_q;
   assign rf_d_in      = result;
   assign rsp_data     = result;
   assign rsp_carry    = carry;
   assign rsp_zero     = zero;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: register file model, transaction-level
// reference model compared every cycle, plus hand-computed expectations.
`timescale 1ns/1ps
module tb_regfile_op_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [2:0]  cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
   logic [15:0] cmd_imm = '0;
   logic [2:0]  rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
   logic [15:0] rf_d_out_a, rf_d_out_b, rf_d_in, rsp_data;
   logic        rf_wr, rsp_valid, rsp_carry, rsp_zero;

   always #5 clk = ~clk;

   regfile_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
      .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
      .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b),
      .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
   );

   // register file the DUT drives (not cleared by reset)
   logic [15:0] rf [8] = '{default: 16'h0000};
   always @(posedge clk) if (rf_wr) rf[rf_wr_addr] <= rf_d_in;
   assign rf_d_out_a = rf[rf_rd_addr_a];
   assign rf_d_out_b = rf[rf_rd_addr_b];

   // reference model: a command is busy for lat cycles and writes in the last
   function automatic logic [17:0] model_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] imm);
      int unsigned ua, ub, r;
      logic c;
      logic [15:0] r16;
      ua = a; ub = b; c = 1'b0; r = 0;
      case (op)
         3'd0: begin r = ua + ub; c = (r > 65535); end
         3'd1: begin r = (ua + 65536 - ub) % 65536; c = (ua < ub); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ua;
         3'd6: r = imm;
         default: r = 65535 - ua;
      endcase
      r16 = r[15:0];
      return {c, (r16 == 16'h0000), r16};
   endfunction

   logic [15:0] mrf [8] = '{default: 16'h0000};
   bit          m_idle = 1, m_armed = 0;
   int          m_k = 0, m_lat = 0;
   logic [2:0]  m_src_a = '0, m_src_b = '0, m_dst = '0;
   logic [15:0] m_res = '0, p_res = '0;
   logic        m_c = 0, m_z = 0, p_c = 0, p_z = 0;

   always @(posedge clk or negedge reset) begin
      logic [17:0] t;
      if (!reset) begin
         m_idle = 1; m_armed = 0; m_k = 0;
         m_src_a = '0; m_src_b = '0; m_dst = '0;
         m_res = '0; m_c = 0; m_z = 0;
      end else begin
         if (!m_idle && m_k == m_lat) begin
            mrf[m_dst] = p_res;
            m_res = p_res; m_c = p_c; m_z = p_z;
            m_idle = 1;
         end else if (!m_idle) begin
            m_k++;
         end else if (m_armed && cmd_valid) begin
            m_idle = 0; m_k = 1;
            m_lat = (cmd_op == 3'd6) ? 1 : 3;
            m_dst = cmd_dst; m_src_a = cmd_src_a; m_src_b = cmd_src_b;
            t = model_alu(cmd_op, mrf[cmd_src_a], mrf[cmd_src_b], cmd_imm);
            p_res = t[15:0]; p_z = t[16]; p_c = t[17];
         end
         m_armed = 1;
      end
   end

   // single checking process: model compare every cycle plus queued literals
   int          checks = 0, errors = 0, rsp_cnt = 0;
   int          lit_seq = 0, lit_seen = 0;
   string       lit_name = "";
   logic [31:0] lit_act = '0, lit_exp = '0;
   bit          ew;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      ew = reset && !m_idle && (m_k == m_lat);
      chk("cmd_ready", 32'(cmd_ready), 32'(reset && m_idle && m_armed));
      chk("rf_wr", 32'(rf_wr), 32'(ew));
      chk("rsp_valid", 32'(rsp_valid), 32'(ew));
      chk("rd_addr_a", 32'(rf_rd_addr_a), 32'(m_src_a));
      chk("rd_addr_b", 32'(rf_rd_addr_b), 32'(m_src_b));
      chk("wr_addr", 32'(rf_wr_addr), 32'(m_dst));
      chk("rf_d_in", 32'(rf_d_in), 32'(ew ? p_res : m_res));
      chk("rsp_data", 32'(rsp_data), 32'(ew ? p_res : m_res));
      chk("rsp_carry", 32'(rsp_carry), 32'(ew ? p_c : m_c));
      chk("rsp_zero", 32'(rsp_zero), 32'(ew ? p_z : m_z));
      if (rsp_valid) rsp_cnt++;
      if (lit_seq != lit_seen) begin
         lit_seen = lit_seq;
         chk(lit_name, lit_act, lit_exp);
      end
   end

   task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
      lit_name = nm; lit_act = a; lit_exp = e;
      lit_seq++;
      @(negedge clk);
      #1;
   endtask

   // stimulus
   logic [31:0] act_log [16];
   logic [31:0] exp_log [16];
   realtime     t_acc [16];
   int          ncmd = 0, acc_to = 0;

   task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] a,
                         input logic [2:0] b, input logic [15:0] imm, input logic [15:0] ed,
                         input logic ec, input logic ez, input bit hold);
      int n;
      bit got;
      logic [15:0] d;
      logic c, z;
      logic [2:0] ra, rb;
      cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
      cmd_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
      if (!cmd_ready) acc_to++;
      @(posedge clk);
      t_acc[ncmd] = $realtime;
      #1;
      if (!hold) cmd_valid = 1'b0;
      n = 0; got = 0; d = '0; c = 0; z = 0; ra = '0; rb = '0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) begin ra = rf_rd_addr_a; rb = rf_rd_addr_b; end
         if (rsp_valid) begin got = 1; d = rsp_data; c = rsp_carry; z = rsp_zero; end
      end
      act_log[ncmd] = {4'h0, n[3:0], ra, rb, d, c, z};
      exp_log[ncmd] = {4'h0, (op == 3'd6) ? 4'd1 : 4'd3, a, b, ed, ec, ez};
      ncmd++;
   endtask

   initial begin
      logic [31:0] rst_snap;
      logic        rdy0, rdy_ab;
      int          rsp_before;

      #7;
      rst_snap = {cmd_ready, rf_wr, rsp_valid, rsp_carry, rsp_zero, rf_wr_addr, rf_d_in};
      #5.5 reset = 1'b1;
      @(negedge clk);
      rdy0 = cmd_ready;

      //     op    dst   a     b     imm        data       c  z  hold
      do_cmd(3'd6, 3'd3, 3'd0, 3'd0, 16'hcdef, 16'hcdef, 0, 0, 0);
      do_cmd(3'd6, 3'd7, 3'd0, 3'd0, 16'h3210, 16'h3210, 0, 0, 0);
      do_cmd(3'd0, 3'd5, 3'd3, 3'd7, 16'h0000, 16'hffff, 0, 0, 0);
      do_cmd(3'd6, 3'd1, 3'd0, 3'd0, 16'h0001, 16'h0001, 0, 0, 0);
      do_cmd(3'd0, 3'd2, 3'd5, 3'd1, 16'h0000, 16'h0000, 1, 1, 0);
      do_cmd(3'd1, 3'd4, 3'd1, 3'd3, 16'h0000, 16'h3212, 1, 0, 0);
      // back-to-back burst with cmd_valid held high
      do_cmd(3'd3, 3'd0, 3'd3, 3'd7, 16'h0000, 16'hffff, 0, 0, 1);
      do_cmd(3'd2, 3'd0, 3'd3, 3'd7, 16'h0000, 16'h0000, 0, 1, 1);
      do_cmd(3'd4, 3'd6, 3'd3, 3'd7, 16'h0000, 16'hffff, 0, 0, 1);
      do_cmd(3'd7, 3'd0, 3'd5, 3'd2, 16'h0000, 16'h0000, 0, 1, 1);
      do_cmd(3'd5, 3'd6, 3'd1, 3'd4, 16'h0000, 16'h0001, 0, 0, 0);

      // ADD r6 = r3 + r1, aborted by reset during EXEC
      @(negedge clk);
      cmd_op = 3'd0; cmd_dst = 3'd6; cmd_src_a = 3'd3; cmd_src_b = 3'd1; cmd_valid = 1'b1;
      begin
         int n;
         n = 0;
         while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
         if (!cmd_ready) acc_to++;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      rsp_before = rsp_cnt;
      @(posedge clk);
      #2 reset = 1'b0;
      #12 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rdy_ab = cmd_ready;
      repeat (4) @(negedge clk);

      lit("reset_outputs", rst_snap, 32'h0);
      lit("ready_after_reset", 32'(rdy0), 32'h1);
      for (int i = 0; i < ncmd; i++) lit($sformatf("cmd%0d", i), act_log[i], exp_log[i]);
      for (int i = 7; i < 11; i++)
         lit($sformatf("spacing%0d", i), 32'(int'((t_acc[i] - t_acc[i-1]) / 10.0)), 32'd4);
      lit("accept_timeouts", 32'(acc_to), 32'd0);
      lit("abort_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
      lit("ready_after_abort", 32'(rdy_ab), 32'h1);
      lit("rf3", 32'(rf[3]), 32'hcdef);
      lit("rf5", 32'(rf[5]), 32'hffff);
      lit("rf2", 32'(rf[2]), 32'h0000);
      lit("rf4", 32'(rf[4]), 32'h3212);
      lit("rf6_unchanged", 32'(rf[6]), 32'h0001);
      lit("rf0", 32'(rf[0]), 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
